// File: rtl/axi_lite_regfile.sv
// AXI-lite slave register file: NUM_REGS registers with byte strobes, read-only
// hardware-fed entries, SLVERR decode and per-register write pulses.
module axi_lite_regfile #(
    parameter int                  AXI_ADDR_WIDTH = 32,
    parameter int                  AXI_DATA_WIDTH = 32,
    parameter int                  NUM_REGS       = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               waddr_valid,
    output logic                               waddr_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]          waddr,
    input  logic                               wdata_valid,
    output logic                               wdata_ready,
    input  logic [AXI_DATA_WIDTH-1:0]          wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]        wstrb,
    output logic                               bresp_valid,
    input  logic                               bresp_ready,
    output logic [1:0]                         bresp,
    input  logic                               raddr_valid,
    output logic                               raddr_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]          raddr,
    output logic                               rdata_valid,
    input  logic                               rdata_ready,
    output logic [AXI_DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                         rresp,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(NUM_REGS * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    r_state_t r_state, r_state_next;

    logic                      ready_en;
    logic                      aw_full, w_full, commit_pending;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                      aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      wr_ok;
    logic [AXI_DATA_WIDTH-1:0] rd_value;
    logic [1:0]                rd_resp;

    // Readys stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    assign waddr_ready = ready_en && !aw_full && !bresp_valid;
    assign wdata_ready = ready_en && !w_full && !bresp_valid;
    assign aw_hs       = waddr_valid && waddr_ready;
    assign w_hs        = wdata_valid && wdata_ready;

    assign wr_idx = aw_addr[LSB +: IDX_W];
    assign wr_ok  = (aw_addr < ADDR_LIMIT) && !RO_MASK[wr_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            commit_pending <= 1'b0;
            aw_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            bresp_valid    <= 1'b0;
            bresp          <= RESP_OKAY;
            wr_pulse       <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= waddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (bresp_valid && bresp_ready) bresp_valid <= 1'b0;
            // Holds stay full through the commit cycle so no new AW/W slips in.
            if (aw_full && w_full && !commit_pending) commit_pending <= 1'b1;
            if (commit_pending) begin
                commit_pending <= 1'b0;
                aw_full        <= 1'b0;
                w_full         <= 1'b0;
                bresp_valid    <= 1'b1;
                if (wr_ok) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b]) regs_q[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                    end
                    wr_pulse[wr_idx] <= 1'b1;
                    bresp            <= RESP_OKAY;
                end else begin
                    bresp <= RESP_SLVERR;
                end
            end
        end
    end

    assign rd_idx = raddr[LSB +: IDX_W];

    always_comb begin
        rd_value = '0;
        rd_resp  = RESP_SLVERR;
        if (raddr < ADDR_LIMIT) begin
            rd_resp  = RESP_OKAY;
            rd_value = RO_MASK[rd_idx] ? reg_in[rd_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                                       : regs_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                rdata <= rd_value;
                rresp <= rd_resp;
            end
        end
    end

    always_comb begin
        r_state_next = r_state;
        raddr_ready  = 1'b0;
        rdata_valid  = 1'b0;
        ar_hs        = 1'b0;
        case (r_state)
            R_IDLE: begin
                raddr_ready = ready_en;
                ar_hs       = raddr_valid && ready_en;
                if (ar_hs) r_state_next = R_RESP;
            end
            R_RESP: begin
                rdata_valid = 1'b1;
                if (rdata_ready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // RO entries mirror reg_in live, forced to 0 while reset is asserted.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                rst_n ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;
        end else begin : g_rw
            assign reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
        end
    end

endmodule
